// File: rtl/tx_fifo_pkg.sv
// Shared configuration helpers for the width-converting TX FIFO.
// TX_FIFO_CFG_CHECK declares CfgOk inside a module from its width/depth parameters.
`ifndef TX_FIFO_CFG_CHECK
`define TX_FIFO_CFG_CHECK(W, R, WD, RD) \
  localparam bit CfgOk = tx_fifo_pkg::cfg_ok(W, R, WD, RD);
`endif

package tx_fifo_pkg;

  typedef enum logic {
    WC_DOWN,
    WC_UP
  } wc_mode_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int ratio(input int wr, input int rd);
    return (wr >= rd) ? wr / rd : rd / wr;
  endfunction

  function automatic int gran(input int wr, input int rd);
    return (wr < rd) ? wr : rd;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit cfg_ok(input int wr, input int rd, input int wd, input int rdd);
    int hi;
    int lo;
    hi = (wr >= rd) ? wr : rd;
    lo = gran(wr, rd);
    if (lo <= 0) return 1'b0;
    if ((hi % lo) != 0) return 1'b0;
    if (!is_pow2(hi / lo)) return 1'b0;
    return (longint'(wr) << wd) == (longint'(rd) << rdd);
  endfunction

endpackage

// File: rtl/tx_fifo_ram.sv
// Simple dual-port RAM, single clock, registered read, per-slice write enables.
module tx_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int SLICES     = 1
) (
  input  logic                  clk_i,
  input  logic [SLICES-1:0]     we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int SW = DATA_WIDTH / SLICES;

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < SLICES; s++) begin
      if (we_i[s]) mem_q[waddr_i][s*SW +: SW] <= wdata_i[s*SW +: SW];
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tx_fifo_wc.sv
// Single-clock TX FIFO with power-of-two width conversion, water levels and sticky errors.
// Define TX_FIFO_OUTPUT_REG_EN to add an rd_data pipeline register (read latency 2).
module tx_fifo_wc
  import tx_fifo_pkg::*;
#(
  parameter int WR_DATA_WIDTH    = 128,
  parameter int RD_DATA_WIDTH    = 8,
  parameter int WR_DEPTH_WIDTH   = 8,
  parameter int RD_DEPTH_WIDTH   = 12,
  parameter int ALMOST_FULL_NUM  = 15,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic                     wr_en,
  output logic                     wr_full,
  output logic                     almost_full,
  output logic [WR_DEPTH_WIDTH:0]  wr_water_level,
  output logic                     overflow,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  input  logic                     rd_en,
  output logic                     rd_empty,
  output logic                     almost_empty,
  output logic [RD_DEPTH_WIDTH:0]  rd_water_level,
  output logic                     underflow
);
  localparam wc_mode_e Mode = (WR_DATA_WIDTH >= RD_DATA_WIDTH) ? WC_DOWN : WC_UP;
  localparam int G    = gran(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int WR_G = WR_DATA_WIDTH / G;
  localparam int RD_G = RD_DATA_WIDTH / G;
  localparam int CAP  = (2**WR_DEPTH_WIDTH) * WR_G;
  localparam int PW   = clog2(CAP) + 1;
  localparam int LWG  = clog2(WR_G);
  localparam int LRG  = clog2(RD_G);
  localparam int WWL  = WR_DEPTH_WIDTH + 1;
  localparam int RWL  = RD_DEPTH_WIDTH + 1;

  `TX_FIFO_CFG_CHECK(WR_DATA_WIDTH, RD_DATA_WIDTH, WR_DEPTH_WIDTH, RD_DEPTH_WIDTH)
  if (!CfgOk) begin : g_cfg_err
    $error("tx_fifo_wc: width ratio must be 2^k and depths must describe the same capacity");
  end

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
  logic           wr_full_q, wr_full_d, rd_empty_q, rd_empty_d;
  logic           almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
  logic           overflow_q, overflow_d, underflow_q, underflow_d;
  logic           rd_vld_q, rd_vld_d;
  logic [WWL-1:0] wr_wl_q, wr_wl_d;
  logic [RWL-1:0] rd_wl_q, rd_wl_d;
  logic           wr_acc, rd_acc;
  logic [RD_DATA_WIDTH-1:0] rd_word, rd_base;

  // Occupancy is the granule distance between pointers; the extra MSB separates full from empty.
  always_comb begin
    wr_acc         = wr_en & ~wr_full_q;
    rd_acc         = rd_en & ~rd_empty_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(WR_G);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(RD_G);
    count_d        = wr_ptr_d - rd_ptr_d;
    wr_full_d      = (PW'(CAP) - count_d) < PW'(WR_G);
    rd_empty_d     = count_d < PW'(RD_G);
    wr_wl_d        = WWL'((count_d + PW'(WR_G - 1)) >> LWG);
    rd_wl_d        = RWL'(count_d >> LRG);
    almost_full_d  = int'(wr_wl_d) >= ALMOST_FULL_NUM;
    almost_empty_d = int'(rd_wl_d) <= ALMOST_EMPTY_NUM;
    overflow_d     = overflow_q | (wr_en & wr_full_q);
    underflow_d    = underflow_q | (rd_en & rd_empty_q);
    rd_vld_d       = rd_vld_q | rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      wr_wl_q        <= '0;
      rd_wl_q        <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      rd_vld_q       <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_full_q      <= wr_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      wr_wl_q        <= wr_wl_d;
      rd_wl_q        <= rd_wl_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      rd_vld_q       <= rd_vld_d;
    end
  end

  if (Mode == WC_DOWN) begin : g_down
    localparam int SELW = (LWG > 0) ? LWG : 1;
    logic [WR_DATA_WIDTH-1:0] ram_rd;
    logic [SELW-1:0]          sel_q;

    tx_fifo_ram #(
      .DATA_WIDTH(WR_DATA_WIDTH),
      .ADDR_WIDTH(WR_DEPTH_WIDTH),
      .SLICES    (1)
    ) u_ram (
      .clk_i  (clk),
      .we_i   (wr_acc),
      .waddr_i(wr_ptr_q[PW-2:LWG]),
      .wdata_i(wr_data),
      .re_i   (rd_acc),
      .raddr_i(rd_ptr_q[PW-2:LWG]),
      .rdata_o(ram_rd)
    );

    // Slice select is captured with the read so the mux tracks the registered RAM word.
    always_ff @(posedge clk) begin
      if (rst)         sel_q <= '0;
      else if (rd_acc) sel_q <= (LWG > 0) ? rd_ptr_q[SELW-1:0] : '0;
    end

    assign rd_word = ram_rd[RD_DATA_WIDTH*int'(sel_q) +: RD_DATA_WIDTH];
  end else begin : g_up
    logic [RD_G-1:0] we;

    always_comb begin
      we = '0;
      we[wr_ptr_q[LRG-1:0]] = wr_acc;
    end

    tx_fifo_ram #(
      .DATA_WIDTH(RD_DATA_WIDTH),
      .ADDR_WIDTH(RD_DEPTH_WIDTH),
      .SLICES    (RD_G)
    ) u_ram (
      .clk_i  (clk),
      .we_i   (we),
      .waddr_i(wr_ptr_q[PW-2:LRG]),
      .wdata_i({RD_G{wr_data}}),
      .re_i   (rd_acc),
      .raddr_i(rd_ptr_q[PW-2:LRG]),
      .rdata_o(rd_word)
    );
  end

  assign rd_base = rd_vld_q ? rd_word : '0;

`ifdef TX_FIFO_OUTPUT_REG_EN
  logic [RD_DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_base;
  end

  assign rd_data = rd_data_q;
`else
  assign rd_data = rd_base;
`endif

  assign wr_full        = wr_full_q;
  assign rd_empty       = rd_empty_q;
  assign almost_full    = almost_full_q;
  assign almost_empty   = almost_empty_q;
  assign wr_water_level = wr_wl_q;
  assign rd_water_level = rd_wl_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

endmodule
